spi_slave_param: RTL and testbench
==================================

# spi_slave_param

Parametrised next-generation SPI slave for the SPI-slave/single-port-RAM subsystem. Deserialises command/payload frames of DATA_WIDTH+2 bits from MOSI into rx_data/rx_valid for the RAM. On read-data commands it serialises the RAM's tx_data back on MISO. Over the fixed 8-bit slave it adds a width parameter, a tx_valid timeout, explicit abort/command-error reporting and a busy status.

## Interface
Parameters:
- DATA_WIDTH, 8, payload width; frame = DATA_WIDTH+2 bits (2 command bits + payload)
- TX_TIMEOUT, 16, max clk cycles to wait for tx_valid in a read-data frame (>=1)

Ports:
- clk  in  1  single system clock; MOSI sampled and MISO driven on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- SS_n  in  1  slave select, active-low
- MOSI  in  1  serial in, MSB first
- MISO  out  1  serial out, MSB first
- rx_data  out  DATA_WIDTH+2  received frame {cmd[1:0], payload}
- rx_valid  out  1  one-cycle strobe, rx_data valid
- tx_data  in  DATA_WIDTH  read data from RAM
- tx_valid  in  1  tx_data valid strobe
- busy  out  1  high whenever state != IDLE
- frame_err  out  1  one-cycle pulse: aborted frame or command mismatch
- rd_timeout  out  1  one-cycle pulse: tx_valid not received within TX_TIMEOUT

## Operation
- Reset values: MISO=0, rx_data=0, rx_valid=0, busy=0, frame_err=0, rd_timeout=0, state=IDLE, rd_addr_seen=0, counters=0.
- States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA, TX_WAIT, TX_SHIFT, HOLD.
- IDLE -> CHK_CMD when SS_n sampled low.
- CHK_CMD samples frame bit W+1 (W=DATA_WIDTH):
  - 0 -> WRITE.
  - 1 and !rd_addr_seen -> READ_ADD.
  - 1 and rd_addr_seen -> READ_DATA.
- WRITE/READ_ADD/READ_DATA shift in the remaining W+1 bits. After the last bit, rx_data updates and rx_valid pulses for one cycle.
- Command check on bit W:
  - READ_ADD requires 0 (cmd 10); READ_DATA requires 1 (cmd 11); WRITE accepts either.
  - On mismatch, suppress rx_valid, pulse frame_err, go to HOLD.
- After a completed frame:
  - WRITE -> HOLD.
  - READ_ADD sets rd_addr_seen, then -> HOLD.
  - READ_DATA -> TX_WAIT.
- TX_WAIT: latch tx_data when tx_valid is high, then -> TX_SHIFT. If TX_TIMEOUT cycles elapse without tx_valid, pulse rd_timeout, clear rd_addr_seen, -> HOLD.
- TX_SHIFT: drive W bits on MISO, MSB first, then clear rd_addr_seen and -> HOLD. MISO=0 in every other state.
- HOLD -> IDLE when SS_n is high.
- Abort: SS_n high in CHK_CMD/WRITE/READ_*/TX_WAIT/TX_SHIFT -> IDLE next cycle. Abort effects:
  - frame_err pulses; no rx_valid is generated.
  - Bit counter clears; rd_addr_seen is unchanged.
- tx_valid outside TX_WAIT is ignored.
- Bit counter is $clog2(W+2) bits wide; timeout counter is $clog2(TX_TIMEOUT+1) bits wide. Neither counter wraps; both reset on state entry.

## Timing
- c0 = first CHK_CMD cycle, i.e. the cycle after SS_n is sampled low. Frame bit W+1-k is sampled at ck, for k=0..W+1.
- rx_valid is high at c(W+2) only.
- TX_WAIT begins at c(W+2); the timeout counter increments from c(W+3).
- tx_valid sampled at cycle t gives MISO = tx_data[W-1] during t+1 through tx_data[0] during t+W. MISO=0 at t+W+1.
- rd_timeout pulses in the cycle the timeout counter reaches TX_TIMEOUT.
- frame_err (abort) pulses the cycle after SS_n is sampled high.
- Async reset mid-frame: all outputs return to reset values immediately, with no frame_err.

## Structure
- shared_pkg:
  - default DATA_WIDTH.
  - typedef enum for the state (8 states).
  - command constants CMD_WR_ADDR=2'b00, CMD_WR_DATA=2'b01, CMD_RD_ADDR=2'b10, CMD_RD_DATA=2'b11.
- Sub-module spi_tx_serializer (load, tx_data, MISO, done), parametrised on DATA_WIDTH. It implements TX_SHIFT.
- The top FSM, deserialiser and timeout counter live in spi_slave_param.

## Test plan
- Write address (W=8): SS_n low, MOSI 00_1010_0101 -> rx_data=10'h0A5, rx_valid=1 at c10 only; busy=1 until SS_n high.
- Read address then read data: send 10_0000_0011, then 11_xxxx_xxxx; drive tx_valid with tx_data=8'h3C two cycles after rx_valid -> MISO 0,0,1,1,1,1,0,0 on the next 8 cycles; rd_addr_seen cleared (next 1-prefixed frame goes to READ_ADD).
- Timeout (TX_TIMEOUT=16): read-data frame with no tx_valid -> rd_timeout pulses 16 cycles after TX_WAIT counting starts; MISO stays 0; next frame decodes as READ_ADD.
- Abort: SS_n high after 5 bits of a write frame -> frame_err pulse the next cycle, no rx_valid, state IDLE.
- Command mismatch: rd_addr_seen=1, send 10_1111_0000 -> no rx_valid, frame_err at c10.
- Reset mid-TX_SHIFT: assert rst_n=0 at bit 3 -> MISO=0, busy=0 immediately; after release, a write frame decodes normally. Re-run all scenarios with DATA_WIDTH=16 (18-bit frames).

Source files
------------

// File: rtl/shared_pkg.sv
// Shared types and constants for the parametrised SPI slave:
// FSM state encoding, command codes and the command-bit check.
package shared_pkg;

   localparam int DEF_DATA_WIDTH = 8;
   localparam int DEF_TX_TIMEOUT = 16;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      CHK_CMD   = 3'd1,
      WRITE     = 3'd2,
      READ_ADD  = 3'd3,
      READ_DATA = 3'd4,
      TX_WAIT   = 3'd5,
      TX_SHIFT  = 3'd6,
      HOLD      = 3'd7
   } state_e;

   localparam logic [1:0] CMD_WR_ADDR = 2'b00;
   localparam logic [1:0] CMD_WR_DATA = 2'b01;
   localparam logic [1:0] CMD_RD_ADDR = 2'b10;
   localparam logic [1:0] CMD_RD_DATA = 2'b11;

   // Second command bit must match the read flavour; writes accept either value.
   function automatic logic cmd_bit_ok(input state_e st, input logic bit_w);
      logic ok;
      case (st)
         READ_ADD:  ok = (bit_w == CMD_RD_ADDR[0]);
         READ_DATA: ok = (bit_w == CMD_RD_DATA[0]);
         default:   ok = 1'b1;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/spi_tx_serializer.sv
// MSB-first serialiser for read data: loads a word, drives it on MISO for
// DATA_WIDTH cycles, flags the final bit with done, then idles MISO low.
module spi_tx_serializer
   import shared_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clr,
   input  logic                  load,
   input  logic [DATA_WIDTH-1:0] tx_data,
   output logic                  MISO,
   output logic                  done
);

   localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

   logic [DATA_WIDTH-1:0] shift_r;
   logic [CW-1:0]         cnt_r;
   logic                  active_r;
   logic                  miso_r;

   assign done = active_r && (cnt_r == CW'(DATA_WIDTH - 1));
   assign MISO = miso_r;

   // Shift engine; the first bit is presented in the cycle right after load.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift_r  <= '0;
         cnt_r    <= '0;
         active_r <= 1'b0;
         miso_r   <= 1'b0;
      end else if (load) begin
         shift_r  <= tx_data << 1;
         cnt_r    <= '0;
         active_r <= 1'b1;
         miso_r   <= tx_data[DATA_WIDTH-1];
      end else if (clr || done) begin
         shift_r  <= '0;
         cnt_r    <= '0;
         active_r <= 1'b0;
         miso_r   <= 1'b0;
      end else if (active_r) begin
         shift_r  <= shift_r << 1;
         cnt_r    <= cnt_r + CW'(1);
         active_r <= 1'b1;
         miso_r   <= shift_r[DATA_WIDTH-1];
      end else begin
         shift_r  <= shift_r;
         cnt_r    <= '0;
         active_r <= 1'b0;
         miso_r   <= 1'b0;
      end
   end

endmodule

// File: rtl/spi_slave_param.sv
// Parametrised SPI slave: frame FSM, MOSI deserialiser, read-data timeout and
// status pulses; MISO serialisation is delegated to spi_tx_serializer.
module spi_slave_param
   import shared_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int TX_TIMEOUT = DEF_TX_TIMEOUT
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  SS_n,
   input  logic                  MOSI,
   output logic                  MISO,
   output logic [DATA_WIDTH+1:0] rx_data,
   output logic                  rx_valid,
   input  logic [DATA_WIDTH-1:0] tx_data,
   input  logic                  tx_valid,
   output logic                  busy,
   output logic                  frame_err,
   output logic                  rd_timeout
);

   localparam int FW = DATA_WIDTH + 2;
   localparam int BW = $clog2(DATA_WIDTH + 2);
   localparam int TW = $clog2(TX_TIMEOUT + 1);

   state_e          state_r, state_s;
   logic [BW-1:0]   bit_cnt_r, bit_cnt_s;
   logic [TW-1:0]   tmo_cnt_r, tmo_cnt_s, tmo_inc_s;
   logic            rd_seen_r, rd_seen_s;
   logic            cmd_bad_r, cmd_bad_s;
   logic [FW-2:0]   shift_r;
   logic [FW-1:0]   frame_s;
   logic [FW-1:0]   rx_data_r;
   logic            rx_valid_r, frame_err_r, rd_timeout_r, busy_r;
   logic            rx_upd_s, rx_valid_s, frame_err_s, rd_timeout_s;
   logic            load_s, clr_s, tx_done_s, last_bit_s;

   assign frame_s    = {shift_r, MOSI};
   assign last_bit_s = (bit_cnt_r == BW'(DATA_WIDTH));
   assign tmo_inc_s  = tmo_cnt_r + TW'(1);

   assign rx_data    = rx_data_r;
   assign rx_valid   = rx_valid_r;
   assign frame_err  = frame_err_r;
   assign rd_timeout = rd_timeout_r;
   assign busy       = busy_r;

   // Next-state and pulse decode; an SS_n release mid-frame always wins.
   always_comb begin
      state_s      = state_r;
      bit_cnt_s    = '0;
      tmo_cnt_s    = '0;
      rd_seen_s    = rd_seen_r;
      cmd_bad_s    = cmd_bad_r;
      rx_upd_s     = 1'b0;
      rx_valid_s   = 1'b0;
      frame_err_s  = 1'b0;
      rd_timeout_s = 1'b0;
      load_s       = 1'b0;
      clr_s        = 1'b0;
      case (state_r)
         IDLE: begin
            if (!SS_n) state_s = CHK_CMD;
            else       state_s = IDLE;
         end
         CHK_CMD: begin
            if (SS_n) begin
               state_s     = IDLE;
               frame_err_s = 1'b1;
            end else begin
               cmd_bad_s = 1'b0;
               if (!MOSI)          state_s = WRITE;
               else if (rd_seen_r) state_s = READ_DATA;
               else                state_s = READ_ADD;
            end
         end
         WRITE, READ_ADD, READ_DATA: begin
            if (SS_n) begin
               state_s     = IDLE;
               frame_err_s = 1'b1;
            end else if (last_bit_s) begin
               if (cmd_bad_r) begin
                  frame_err_s = 1'b1;
                  state_s     = HOLD;
               end else begin
                  rx_upd_s   = 1'b1;
                  rx_valid_s = 1'b1;
                  case (state_r)
                     READ_ADD: begin
                        rd_seen_s = 1'b1;
                        state_s   = HOLD;
                     end
                     READ_DATA: state_s = TX_WAIT;
                     default:   state_s = HOLD;
                  endcase
               end
            end else begin
               bit_cnt_s = bit_cnt_r + BW'(1);
               if ((bit_cnt_r == '0) && !cmd_bit_ok(state_r, MOSI)) cmd_bad_s = 1'b1;
               else                                                 cmd_bad_s = cmd_bad_r;
            end
         end
         TX_WAIT: begin
            if (SS_n) begin
               state_s     = IDLE;
               frame_err_s = 1'b1;
            end else if (tx_valid) begin
               load_s  = 1'b1;
               state_s = TX_SHIFT;
            end else if (tmo_inc_s == TW'(TX_TIMEOUT)) begin
               rd_timeout_s = 1'b1;
               rd_seen_s    = 1'b0;
               state_s      = HOLD;
            end else begin
               tmo_cnt_s = tmo_inc_s;
            end
         end
         TX_SHIFT: begin
            if (SS_n) begin
               state_s     = IDLE;
               frame_err_s = 1'b1;
               clr_s       = 1'b1;
            end else if (tx_done_s) begin
               rd_seen_s = 1'b0;
               state_s   = HOLD;
            end else begin
               state_s = TX_SHIFT;
            end
         end
         HOLD: begin
            if (SS_n) state_s = IDLE;
            else      state_s = HOLD;
         end
         default: state_s = IDLE;
      endcase
   end

   // State, counters, deserialiser and registered status outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r      <= IDLE;
         bit_cnt_r    <= '0;
         tmo_cnt_r    <= '0;
         rd_seen_r    <= 1'b0;
         cmd_bad_r    <= 1'b0;
         shift_r      <= '0;
         rx_data_r    <= '0;
         rx_valid_r   <= 1'b0;
         frame_err_r  <= 1'b0;
         rd_timeout_r <= 1'b0;
         busy_r       <= 1'b0;
      end else begin
         state_r      <= state_s;
         bit_cnt_r    <= bit_cnt_s;
         tmo_cnt_r    <= tmo_cnt_s;
         rd_seen_r    <= rd_seen_s;
         cmd_bad_r    <= cmd_bad_s;
         shift_r      <= frame_s[FW-2:0];
         rx_valid_r   <= rx_valid_s;
         frame_err_r  <= frame_err_s;
         rd_timeout_r <= rd_timeout_s;
         busy_r       <= (state_s != IDLE);
         if (rx_upd_s) rx_data_r <= frame_s;
         else          rx_data_r <= rx_data_r;
      end
   end

   spi_tx_serializer #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_tx (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (clr_s),
      .load    (load_s),
      .tx_data (tx_data),
      .MISO    (MISO),
      .done    (tx_done_s)
   );

endmodule

// File: tb/tb_spi_slave_param.sv
// Directed bench for spi_slave_param: one 8-bit instance (timeout 16) and one
// 16-bit instance (timeout 4), selected by sel16 and driven from a single sequence.
module tb_spi_slave_param;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ss_n = 1'b1;
   logic        mosi = 1'b0;
   logic        tx_valid = 1'b0;
   logic [15:0] tx_data = 16'h0000;
   logic        sel16 = 1'b0;

   int n_chk = 0;
   int n_fail = 0;

   logic        miso_a, rx_valid_a, busy_a, ferr_a, tmo_a;
   logic [9:0]  rx_a;
   logic        miso_b, rx_valid_b, busy_b, ferr_b, tmo_b;
   logic [17:0] rx_b;

   logic        miso_o, rx_valid_o, busy_o, ferr_o, tmo_o;
   logic [17:0] rx_o;

   always #5 clk = ~clk;

   spi_slave_param #(.DATA_WIDTH(8), .TX_TIMEOUT(16)) dut_a (
      .clk        (clk),
      .rst_n      (rst_n),
      .SS_n       (sel16 ? 1'b1 : ss_n),
      .MOSI       (mosi),
      .MISO       (miso_a),
      .rx_data    (rx_a),
      .rx_valid   (rx_valid_a),
      .tx_data    (tx_data[7:0]),
      .tx_valid   (sel16 ? 1'b0 : tx_valid),
      .busy       (busy_a),
      .frame_err  (ferr_a),
      .rd_timeout (tmo_a)
   );

   spi_slave_param #(.DATA_WIDTH(16), .TX_TIMEOUT(4)) dut_b (
      .clk        (clk),
      .rst_n      (rst_n),
      .SS_n       (sel16 ? ss_n : 1'b1),
      .MOSI       (mosi),
      .MISO       (miso_b),
      .rx_data    (rx_b),
      .rx_valid   (rx_valid_b),
      .tx_data    (tx_data),
      .tx_valid   (sel16 ? tx_valid : 1'b0),
      .busy       (busy_b),
      .frame_err  (ferr_b),
      .rd_timeout (tmo_b)
   );

   assign miso_o     = sel16 ? miso_b     : miso_a;
   assign rx_valid_o = sel16 ? rx_valid_b : rx_valid_a;
   assign busy_o     = sel16 ? busy_b     : busy_a;
   assign ferr_o     = sel16 ? ferr_b     : ferr_a;
   assign tmo_o      = sel16 ? tmo_b      : tmo_a;
   assign rx_o       = sel16 ? rx_b       : {8'd0, rx_a};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drives a complete frame; returns in cycle c(w+2).
   task automatic start_frame(input int w, input logic [17:0] fr);
      ss_n = 1'b0;
      mosi = fr[w+1];
      tick();
      for (int k = 0; k <= w + 1; k++) begin
         chk("rx_valid_mid_frame", {31'd0, rx_valid_o}, 32'd0);
         chk("busy_mid_frame", {31'd0, busy_o}, 32'd1);
         mosi = fr[w+1-k];
         tick();
      end
   endtask

   task automatic end_frame();
      ss_n = 1'b1;
      mosi = 1'b0;
      tick();
      tick();
      chk("busy_after_release", {31'd0, busy_o}, 32'd0);
   endtask

   // Waits dly cycles in TX_WAIT, strobes tx_valid, then checks the MISO bit train.
   task automatic check_tx(input int w, input logic [15:0] d, input int dly);
      for (int i = 0; i < dly; i++) begin
         chk("miso_tx_wait", {31'd0, miso_o}, 32'd0);
         tick();
      end
      tx_valid = 1'b1;
      tx_data  = d;
      chk("miso_before_load", {31'd0, miso_o}, 32'd0);
      tick();
      tx_valid = 1'b0;
      for (int b = 0; b < w; b++) begin
         chk("miso_bit", {31'd0, miso_o}, {31'd0, d[w-1-b]});
         tick();
      end
      chk("miso_after_shift", {31'd0, miso_o}, 32'd0);
   endtask

   initial begin
      // Reset state
      #2;
      chk("reset_miso", {31'd0, miso_o}, 32'd0);
      chk("reset_rx_data", {14'd0, rx_o}, 32'd0);
      chk("reset_rx_valid", {31'd0, rx_valid_o}, 32'd0);
      chk("reset_busy", {31'd0, busy_o}, 32'd0);
      chk("reset_frame_err", {31'd0, ferr_o}, 32'd0);
      chk("reset_rd_timeout", {31'd0, tmo_o}, 32'd0);
      tick();
      rst_n = 1'b1;
      tick();

      // Write address 00_1010_0101
      start_frame(8, 18'h000A5);
      chk("wr_rx_valid", {31'd0, rx_valid_o}, 32'd1);
      chk("wr_rx_data", {14'd0, rx_o}, 32'h0A5);
      chk("wr_frame_err", {31'd0, ferr_o}, 32'd0);
      tick();
      chk("wr_rx_valid_one_cycle", {31'd0, rx_valid_o}, 32'd0);
      chk("wr_busy_hold", {31'd0, busy_o}, 32'd1);
      end_frame();

      // Read address, then read data with tx_valid two cycles after rx_valid
      start_frame(8, 18'h00203);
      chk("rda_rx_valid", {31'd0, rx_valid_o}, 32'd1);
      chk("rda_rx_data", {14'd0, rx_o}, 32'h203);
      end_frame();
      start_frame(8, 18'h003FF);
      chk("rdd_rx_valid", {31'd0, rx_valid_o}, 32'd1);
      chk("rdd_rx_data", {14'd0, rx_o}, 32'h3FF);
      check_tx(8, 16'h003C, 2);
      tx_valid = 1'b1;
      tx_data  = 16'h00FF;
      tick();
      tx_valid = 1'b0;
      chk("tx_valid_ignored_in_hold", {31'd0, miso_o}, 32'd0);
      end_frame();
      // rd_addr_seen cleared: 10-prefixed frame is a valid READ_ADD
      start_frame(8, 18'h002F0);
      chk("post_tx_read_add", {31'd0, rx_valid_o}, 32'd1);
      chk("post_tx_no_err", {31'd0, ferr_o}, 32'd0);
      end_frame();

      // Command mismatch: READ_DATA expected, cmd 10 received
      start_frame(8, 18'h002F0);
      chk("mismatch_rx_valid", {31'd0, rx_valid_o}, 32'd0);
      chk("mismatch_frame_err", {31'd0, ferr_o}, 32'd1);
      tick();
      chk("mismatch_err_one_cycle", {31'd0, ferr_o}, 32'd0);
      end_frame();

      // Timeout: no tx_valid for 16 cycles
      start_frame(8, 18'h003AA);
      chk("tmo_rx_valid", {31'd0, rx_valid_o}, 32'd1);
      for (int j = 0; j < 16; j++) begin
         chk("tmo_not_yet", {31'd0, tmo_o}, 32'd0);
         chk("tmo_miso_low", {31'd0, miso_o}, 32'd0);
         tick();
      end
      chk("tmo_pulse", {31'd0, tmo_o}, 32'd1);
      tick();
      chk("tmo_pulse_one_cycle", {31'd0, tmo_o}, 32'd0);
      end_frame();
      start_frame(8, 18'h00255);
      chk("post_tmo_read_add", {31'd0, rx_valid_o}, 32'd1);
      chk("post_tmo_rx_data", {14'd0, rx_o}, 32'h255);
      end_frame();

      // Abort after 5 bits of a write frame
      ss_n = 1'b0;
      mosi = 1'b0;
      tick();
      for (int k = 0; k < 5; k++) begin
         mosi = 1'b0;
         tick();
      end
      ss_n = 1'b1;
      chk("abort_no_err_yet", {31'd0, ferr_o}, 32'd0);
      tick();
      chk("abort_frame_err", {31'd0, ferr_o}, 32'd1);
      chk("abort_rx_valid", {31'd0, rx_valid_o}, 32'd0);
      chk("abort_idle", {31'd0, busy_o}, 32'd0);
      tick();
      chk("abort_err_one_cycle", {31'd0, ferr_o}, 32'd0);
      // rd_addr_seen kept across abort: 11-prefixed frame accepted as READ_DATA
      start_frame(8, 18'h003C3);
      chk("abort_keeps_rd_seen", {31'd0, rx_valid_o}, 32'd1);

      // Reset during TX_SHIFT at bit 3 of 0xA5
      tx_valid = 1'b1;
      tx_data  = 16'h00A5;
      tick();
      tx_valid = 1'b0;
      chk("rst_tx_bit7", {31'd0, miso_o}, 32'd1);
      tick();
      chk("rst_tx_bit6", {31'd0, miso_o}, 32'd0);
      tick();
      chk("rst_tx_bit5", {31'd0, miso_o}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("rst_mid_miso", {31'd0, miso_o}, 32'd0);
      chk("rst_mid_busy", {31'd0, busy_o}, 32'd0);
      chk("rst_mid_frame_err", {31'd0, ferr_o}, 32'd0);
      chk("rst_mid_rx_data", {14'd0, rx_o}, 32'd0);
      ss_n = 1'b1;
      tick();
      rst_n = 1'b1;
      tick();
      start_frame(8, 18'h0015A);
      chk("post_rst_rx_valid", {31'd0, rx_valid_o}, 32'd1);
      chk("post_rst_rx_data", {14'd0, rx_o}, 32'h15A);
      end_frame();

      // 16-bit instance, TX_TIMEOUT=4
      sel16 = 1'b1;
      tick();
      start_frame(16, 18'h11234);
      chk("w16_wr_rx_valid", {31'd0, rx_valid_o}, 32'd1);
      chk("w16_wr_rx_data", {14'd0, rx_o}, 32'h11234);
      end_frame();
      start_frame(16, 18'h2ABCD);
      chk("w16_rda_rx_data", {14'd0, rx_o}, 32'h2ABCD);
      end_frame();
      start_frame(16, 18'h30000);
      chk("w16_rdd_rx_valid", {31'd0, rx_valid_o}, 32'd1);
      check_tx(16, 16'hC3A5, 0);
      end_frame();
      start_frame(16, 18'h20001);
      chk("w16_rda2_rx_valid", {31'd0, rx_valid_o}, 32'd1);
      end_frame();
      start_frame(16, 18'h3FFFF);
      chk("w16_rdd2_rx_valid", {31'd0, rx_valid_o}, 32'd1);
      for (int j = 0; j < 4; j++) begin
         chk("w16_tmo_not_yet", {31'd0, tmo_o}, 32'd0);
         tick();
      end
      chk("w16_tmo_pulse", {31'd0, tmo_o}, 32'd1);
      end_frame();
      // rd_addr_seen cleared by timeout: cmd 11 decodes as READ_ADD and mismatches
      start_frame(16, 18'h3FFFF);
      chk("w16_mismatch_rx_valid", {31'd0, rx_valid_o}, 32'd0);
      chk("w16_mismatch_frame_err", {31'd0, ferr_o}, 32'd1);
      end_frame();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
